// File: rtl/sobel_window_gen_if.sv
// Pixel stream in / 3x3 window out bundle for sobel_window_gen.
// The slave modport is the window generator's view; the master modport is
// the view of whatever drives pixels and consumes windows.
interface sobel_window_gen_if;
  logic [23:0] PIX_IN;
  logic        PIX_VALID;
  logic        SOF;
  logic [23:0] D00, D01, D02;
  logic [23:0] D10, D11, D12;
  logic [23:0] D20, D21, D22;
  logic        WIN_VALID;
  logic        WIN_EOL;
  logic        WIN_EOF;

  modport slave (
    input  PIX_IN, PIX_VALID, SOF,
    output D00, D01, D02, D10, D11, D12, D20, D21, D22,
    output WIN_VALID, WIN_EOL, WIN_EOF
  );

  modport master (
    output PIX_IN, PIX_VALID, SOF,
    input  D00, D01, D02, D10, D11, D12, D20, D21, D22,
    input  WIN_VALID, WIN_EOL, WIN_EOF
  );
endinterface

// File: rtl/sobel_window_gen.sv
// 3x3 window generator for the sobel filter. Two line buffers hold rows r-1
// and r-2; each accepted pixel reads both buffers at its column, captures the
// resulting column one cycle later and shifts it into the window the cycle
// after that. Windows are flagged only once two rows and two columns exist.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic               CLK,
  input  logic               RESET,
  sobel_window_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;

  logic               accept_s;
  logic [COL_W-1:0]   cur_col_s;
  logic [ROW_W-1:0]   cur_row_s;
  logic               last_col_s;
  logic               last_row_s;
  logic               win_pos_s;
  logic [23:0]        lb1_rd_s;
  logic [23:0]        lb0_rd_s;

  // Line buffers: LB1 holds row r-1, LB0 holds row r-2 (not reset).
  logic [23:0]        lb1_q [IMG_WIDTH];
  logic [23:0]        lb0_q [IMG_WIDTH];

  // Stage 1: captured column and its flags.
  logic               s1_acc_q;
  logic               s1_win_q;
  logic               s1_eol_q;
  logic               s1_eof_q;
  logic [23:0]        s1_top_q, s1_mid_q, s1_bot_q;

  // Stage 2: window [line][column], line 0 = oldest, column 0 = newest.
  logic [2:0][2:0][23:0] win_q;
  logic               win_valid_q;
  logic               win_eol_q;
  logic               win_eof_q;

  assign lb1_rd_s = lb1_q[cur_col_s];
  assign lb0_rd_s = lb0_q[cur_col_s];

  // Accept decision, pixel position and next frame-tracking state.
  always_comb begin
    accept_s   = 1'b0;
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    case (state_q)
      ST_ACTIVE: accept_s = bus.PIX_VALID;
      ST_IDLE,
      ST_DONE:   accept_s = bus.PIX_VALID & bus.SOF;
      default:   accept_s = 1'b0;
    endcase
    // A SOF pixel is always (0,0), even if it interrupts a running frame.
    if (bus.SOF) begin
      cur_col_s = {COL_W{1'b0}};
      cur_row_s = {ROW_W{1'b0}};
    end else begin
      cur_col_s = col_q;
      cur_row_s = row_q;
    end
    last_col_s = (cur_col_s == COL_LAST);
    last_row_s = (cur_row_s == ROW_LAST);
    win_pos_s  = (cur_row_s >= ROW_W'(2)) && (cur_col_s >= COL_W'(2));
    if (accept_s) begin
      if (last_col_s && last_row_s) begin
        state_d = ST_DONE;
        col_d   = {COL_W{1'b0}};
        row_d   = {ROW_W{1'b0}};
      end else if (last_col_s) begin
        state_d = ST_ACTIVE;
        col_d   = {COL_W{1'b0}};
        row_d   = cur_row_s + ROW_W'(1);
      end else begin
        state_d = ST_ACTIVE;
        col_d   = cur_col_s + COL_W'(1);
        row_d   = cur_row_s;
      end
    end else begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
    end
  end

  // Frame-tracking registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      col_q   <= {COL_W{1'b0}};
      row_q   <= {ROW_W{1'b0}};
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Read-first line buffer update: the pixel enters LB1, the old LB1 word moves to LB0.
  always_ff @(posedge CLK) begin
    if (accept_s) begin
      lb1_q[cur_col_s] <= bus.PIX_IN;
      lb0_q[cur_col_s] <= lb1_rd_s;
    end
  end

  // Stage 1: capture the new column and the window/position flags.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      s1_acc_q <= 1'b0;
      s1_win_q <= 1'b0;
      s1_eol_q <= 1'b0;
      s1_eof_q <= 1'b0;
      s1_top_q <= 24'h000000;
      s1_mid_q <= 24'h000000;
      s1_bot_q <= 24'h000000;
    end else begin
      s1_acc_q <= accept_s;
      s1_win_q <= accept_s & win_pos_s;
      s1_eol_q <= accept_s & last_col_s;
      s1_eof_q <= accept_s & last_col_s & last_row_s;
      if (accept_s) begin
        s1_top_q <= lb0_rd_s;
        s1_mid_q <= lb1_rd_s;
        s1_bot_q <= bus.PIX_IN;
      end
    end
  end

  // Stage 2: shift the captured column into the window and raise the flags.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_eol_q   <= 1'b0;
      win_eof_q   <= 1'b0;
    end else begin
      win_valid_q <= s1_win_q;
      win_eol_q   <= s1_win_q & s1_eol_q;
      win_eof_q   <= s1_win_q & s1_eof_q;
      if (s1_acc_q) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i][2] <= win_q[i][1];
          win_q[i][1] <= win_q[i][0];
        end
        win_q[0][0] <= s1_top_q;
        win_q[1][0] <= s1_mid_q;
        win_q[2][0] <= s1_bot_q;
      end
    end
  end

  assign bus.D00       = win_q[0][0];
  assign bus.D01       = win_q[0][1];
  assign bus.D02       = win_q[0][2];
  assign bus.D10       = win_q[1][0];
  assign bus.D11       = win_q[1][1];
  assign bus.D12       = win_q[1][2];
  assign bus.D20       = win_q[2][0];
  assign bus.D21       = win_q[2][1];
  assign bus.D22       = win_q[2][2];
  assign bus.WIN_VALID = win_valid_q;
  assign bus.WIN_EOL   = win_eol_q;
  assign bus.WIN_EOF   = win_eof_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 image. A reference model keeps the
// current frame as a 2-D array and, for every accepted pixel, forms the
// expected window directly from the image plus a two-cycle delay.
module tb_sobel_window_gen;
  localparam int W = 4;
  localparam int H = 4;

  logic CLK;
  logic RESET;
  sobel_window_gen_if bus ();

  sobel_window_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .COL_W     (2),
    .ROW_W     (2)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec;
  int n_miss;
  int win_pulses;

  // Reference model state.
  bit           m_in_frame;
  int           m_r, m_c;
  logic [23:0]  img [H][W];
  bit           s1_acc, s1_win;
  logic [2:0]   s1_flags;
  logic [215:0] s1_data;
  logic [2:0]   exp_flags;
  logic [215:0] exp_win;
  bit           exp_known;

  function automatic logic [23:0] pix_rc(input int r, input int c);
    logic [7:0] b;
    b = {r[3:0], c[3:0]};
    return {b, b, b};
  endfunction

  task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit v, input bit s, input logic [23:0] p, input bit rst_v);
    bit           acc;
    int           r, c;
    bit           n_win;
    logic [2:0]   n_flags;
    logic [215:0] n_data;
    logic [215:0] obs_win;
    bus.PIX_VALID = v;
    bus.SOF       = s;
    bus.PIX_IN    = p;
    RESET         = rst_v;
    acc     = v && (s || m_in_frame);
    r       = s ? 0 : m_r;
    c       = s ? 0 : m_c;
    n_win   = 1'b0;
    n_flags = 3'b000;
    n_data  = '0;
    if (acc) begin
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        n_win   = 1'b1;
        n_data  = {img[r-2][c], img[r-2][c-1], img[r-2][c-2],
                   img[r-1][c], img[r-1][c-1], img[r-1][c-2],
                   img[r][c],   img[r][c-1],   img[r][c-2]};
        n_flags = {1'b1, (c == W-1), (r == H-1) && (c == W-1)};
      end
      if (r == H-1 && c == W-1) begin
        m_in_frame = 1'b0;
        m_r = 0;
        m_c = 0;
      end else begin
        m_in_frame = 1'b1;
        if (c == W-1) begin
          m_c = 0;
          m_r = r + 1;
        end else begin
          m_c = c + 1;
          m_r = r;
        end
      end
    end
    @(posedge CLK);
    #1;
    if (!rst_v) begin
      m_in_frame = 1'b0;
      m_r = 0;
      m_c = 0;
      s1_acc = 1'b0;
      s1_win = 1'b0;
      exp_flags = 3'b000;
      exp_win = '0;
      exp_known = 1'b1;
    end else begin
      if (s1_acc) begin
        if (s1_win) begin
          exp_win   = s1_data;
          exp_known = 1'b1;
        end else begin
          exp_known = 1'b0;
        end
      end
      exp_flags = s1_win ? s1_flags : 3'b000;
      s1_acc   = acc;
      s1_win   = n_win;
      s1_data  = n_data;
      s1_flags = n_flags;
    end
    if (bus.WIN_VALID === 1'b1) win_pulses++;
    chk("flags", {213'd0, bus.WIN_VALID, bus.WIN_EOL, bus.WIN_EOF}, {213'd0, exp_flags});
    if (exp_known) begin
      obs_win = {bus.D00, bus.D01, bus.D02, bus.D10, bus.D11, bus.D12,
                 bus.D20, bus.D21, bus.D22};
      chk("window", obs_win, exp_win);
    end
  endtask

  // n pixels in raster order starting at linear index start; gap<0 means random gaps.
  task automatic send_seq(input int start, input int n, input bit sof_first,
                          input bit fmt, input int gap);
    int g;
    logic [23:0] d;
    for (int i = 0; i < n; i++) begin
      d = fmt ? pix_rc((start + i) / W, (start + i) % W) : 24'($urandom);
      cycle(1'b1, sof_first && (i == 0), d, 1'b1);
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) cycle(1'b0, 1'($urandom), 24'($urandom), 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 24'($urandom), 1'b1);
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    win_pulses = 0;
    m_in_frame = 1'b0;
    m_r = 0;
    m_c = 0;
    s1_acc = 1'b0;
    s1_win = 1'b0;
    s1_flags = 3'b000;
    s1_data = '0;
    exp_flags = 3'b000;
    exp_win = '0;
    exp_known = 1'b1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 24'h000000;
    bus.PIX_VALID = 1'b0;
    bus.SOF = 1'b0;
    bus.PIX_IN = 24'h000000;
    RESET = 1'b0;

    // Reset state.
    cycle(1'b0, 1'b0, 24'h000000, 1'b0);
    cycle(1'b0, 1'b0, 24'h000000, 1'b0);

    // Pixels without SOF after reset are dropped.
    win_pulses = 0;
    send_seq(0, 6, 1'b0, 1'b0, 0);
    idle(3);
    chk("nosof_count", 216'(win_pulses), 216'd0);

    // Full frame, continuous, pattern data; first window checked against constants.
    win_pulses = 0;
    send_seq(0, 12, 1'b1, 1'b1, 0);
    chk("first_d20", {192'd0, bus.D20}, {192'd0, 24'h222222});
    chk("first_d22", {192'd0, bus.D22}, {192'd0, 24'h202020});
    chk("first_d11", {192'd0, bus.D11}, {192'd0, 24'h111111});
    chk("first_d00", {192'd0, bus.D00}, {192'd0, 24'h020202});
    send_seq(12, 4, 1'b0, 1'b1, 0);
    idle(3);
    chk("cont_count", 216'(win_pulses), 216'd4);

    // Same frame with a pixel every third cycle.
    win_pulses = 0;
    send_seq(0, 16, 1'b1, 1'b1, 2);
    idle(3);
    chk("slow_count", 216'(win_pulses), 216'd4);

    // Early restart at pixel (2,1), then a full new frame.
    win_pulses = 0;
    send_seq(0, 9, 1'b1, 1'b0, 0);
    send_seq(0, 16, 1'b1, 1'b0, 0);
    idle(3);
    chk("restart_count", 216'(win_pulses), 216'd4);

    // Reset one cycle after the last pixel discards the window in flight.
    win_pulses = 0;
    send_seq(0, 16, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 24'h000000, 1'b0);
    idle(3);
    chk("reset_count", 216'(win_pulses), 216'd3);

    // Two frames back to back.
    win_pulses = 0;
    send_seq(0, 16, 1'b1, 1'b0, 0);
    send_seq(0, 16, 1'b1, 1'b0, 0);
    idle(3);
    chk("b2b_count", 216'(win_pulses), 216'd8);

    // Random gaps and random data.
    win_pulses = 0;
    send_seq(0, 16, 1'b1, 1'b0, -1);
    idle(3);
    chk("rand_count", 216'(win_pulses), 216'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
